// File: rtl/vga_pkg.sv
// Shared constants, control codes and state encoding for the console text controller.
package vga_pkg;

  localparam int N_COL          = 80;
  localparam int N_ROW          = 30;
  localparam int WORDS_PER_ROW  = N_COL / 4;
  localparam int TOTAL_WORDS    = N_ROW * N_COL / 4;
  localparam int BUF_ADDR_WIDTH = 10;
  localparam int DATA_WIDTH     = 32;

  localparam logic [7:0] FILL_CHAR = 8'h20;
  localparam logic [7:0] CODE_CR   = 8'h0D;
  localparam logic [7:0] CODE_LF   = 8'h0A;
  localparam logic [7:0] CODE_BS   = 8'h08;
  localparam logic [7:0] CODE_FF   = 8'h0C;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WRITE    = 2'd1,
    ST_CLR_LINE = 2'd2,
    ST_CLR_ALL  = 2'd3
  } state_t;

  function automatic logic [4:0] next_row(input logic [4:0] row);
    return (row == 5'(N_ROW - 1)) ? 5'd0 : row + 5'd1;
  endfunction

  // Tile index fits in 12 bits (max 2399); word address is tile[11:2].
  function automatic logic [11:0] tile_of(input logic [4:0] row, input logic [6:0] col);
    return 12'(row) * 12'(N_COL) + 12'(col);
  endfunction

  function automatic logic [9:0] row_base(input logic [4:0] row);
    return 10'(row) * 10'(WORDS_PER_ROW);
  endfunction

endpackage

// File: rtl/vga_fill_seq.sv
// Walks a run of consecutive word addresses under req/gnt; one word per granted cycle.
module vga_fill_seq
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] base,
  input  logic [9:0] count,
  input  logic       gnt,
  output logic       req,
  output logic [9:0] addr,
  output logic       done
);

  logic [9:0] idx;
  logic [9:0] last_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req      <= 1'b0;
      addr     <= '0;
      idx      <= '0;
      last_idx <= '0;
    end else if (start) begin
      req      <= 1'b1;
      addr     <= base;
      idx      <= '0;
      last_idx <= count - 10'd1;
    end else if (req && gnt) begin
      if (idx == last_idx) begin
        req <= 1'b0;
      end else begin
        addr <= addr + 10'd1;
        idx  <= idx + 10'd1;
      end
    end
  end

  // Pulses in the cycle the final word is granted.
  assign done = req && gnt && (idx == last_idx);

endmodule

// File: rtl/vga_console_ctrl.sv
// Terminal-style character stream to text-buffer writer with cursor, control codes and clears.
module vga_console_ctrl
  import vga_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      char_valid_i,
  input  logic [7:0]                char_data_i,
  output logic                      char_ready_o,
  output logic                      buf_req_o,
  input  logic                      buf_gnt_i,
  output logic [BUF_ADDR_WIDTH-1:0] buf_waddr_o,
  output logic [DATA_WIDTH-1:0]     buf_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   buf_wstrb_o,
  output logic [6:0]                cursor_col_o,
  output logic [4:0]                cursor_row_o,
  output logic                      busy_o
);

  // Handshake: a word is written in the cycle where buf_req_o && buf_gnt_i;
  // req, address, data and strobe are held unchanged until that cycle, and a
  // character is taken in the cycle where char_valid_i && char_ready_o.

  state_t                      state;
  logic [6:0]                  col;
  logic [4:0]                  row;
  logic                        wr_req;
  logic [BUF_ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]       wr_data;
  logic [DATA_WIDTH/8-1:0]     wr_strb;
  logic                        bs_write;
  logic                        fill_start;
  logic [9:0]                  fill_base;
  logic [9:0]                  fill_count;
  logic                        fill_req;
  logic [9:0]                  fill_addr;
  logic                        fill_done;
  logic [11:0]                 tile_cur;
  logic [11:0]                 tile_bs;
  logic                        printable;

  assign tile_cur  = tile_of(row, col);
  assign tile_bs   = tile_of(row, col - 7'd1);
  assign printable = (char_data_i >= 8'h20) && (char_data_i <= 8'h7E);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      col        <= '0;
      row        <= '0;
      wr_req     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_strb    <= '0;
      bs_write   <= 1'b0;
      fill_start <= 1'b0;
      fill_base  <= '0;
      fill_count <= '0;
    end else begin
      fill_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (char_valid_i) begin
            if (printable) begin
              wr_req   <= 1'b1;
              wr_addr  <= tile_cur[11:2];
              wr_strb  <= 4'b0001 << tile_cur[1:0];
              wr_data  <= {4{char_data_i}};
              bs_write <= 1'b0;
              state    <= ST_WRITE;
            end else if (char_data_i == CODE_CR) begin
              col <= '0;
            end else if (char_data_i == CODE_LF) begin
              row        <= next_row(row);
              fill_base  <= row_base(next_row(row));
              fill_count <= 10'(WORDS_PER_ROW);
              fill_start <= 1'b1;
              state      <= ST_CLR_LINE;
            end else if (char_data_i == CODE_BS && col != 7'd0) begin
              col      <= col - 7'd1;
              wr_req   <= 1'b1;
              wr_addr  <= tile_bs[11:2];
              wr_strb  <= 4'b0001 << tile_bs[1:0];
              wr_data  <= {4{FILL_CHAR}};
              bs_write <= 1'b1;
              state    <= ST_WRITE;
            end else if (char_data_i == CODE_FF) begin
              col        <= '0;
              row        <= '0;
              fill_base  <= '0;
              fill_count <= 10'(TOTAL_WORDS);
              fill_start <= 1'b1;
              state      <= ST_CLR_ALL;
            end
          end
        end
        ST_WRITE: begin
          if (buf_gnt_i) begin
            wr_req <= 1'b0;
            if (bs_write) begin
              state <= ST_IDLE;
            end else if (col == 7'(N_COL - 1)) begin
              // Wrapping off the last column behaves like CR+LF, including the line clear.
              col        <= '0;
              row        <= next_row(row);
              fill_base  <= row_base(next_row(row));
              fill_count <= 10'(WORDS_PER_ROW);
              fill_start <= 1'b1;
              state      <= ST_CLR_LINE;
            end else begin
              col   <= col + 7'd1;
              state <= ST_IDLE;
            end
          end
        end
        ST_CLR_LINE, ST_CLR_ALL: begin
          if (fill_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  vga_fill_seq u_fill (
    .clk   (clk_i),
    .rst   (rst_i),
    .start (fill_start),
    .base  (fill_base),
    .count (fill_count),
    .gnt   (buf_gnt_i),
    .req   (fill_req),
    .addr  (fill_addr),
    .done  (fill_done)
  );

  // Single writes and fill runs never overlap, so the port is a plain select.
  assign buf_req_o    = wr_req | fill_req;
  assign buf_waddr_o  = fill_req ? fill_addr : wr_addr;
  assign buf_wdata_o  = fill_req ? {4{FILL_CHAR}} : wr_data;
  assign buf_wstrb_o  = fill_req ? 4'hF : wr_strb;
  assign cursor_col_o = col;
  assign cursor_row_o = row;
  assign busy_o       = (state != ST_IDLE);
  assign char_ready_o = (state == ST_IDLE);

endmodule

// File: tb/tb_vga_console_ctrl.sv
// Directed bench for vga_console_ctrl with an expected-write queue and a decoupled write monitor.
module tb_vga_console_ctrl;

  logic        clk;
  logic        rst_i;
  logic        char_valid_i;
  logic [7:0]  char_data_i;
  logic        char_ready_o;
  logic        buf_req_o;
  logic        buf_gnt_i;
  logic [9:0]  buf_waddr_o;
  logic [31:0] buf_wdata_o;
  logic [3:0]  buf_wstrb_o;
  logic [6:0]  cursor_col_o;
  logic [4:0]  cursor_row_o;
  logic        busy_o;

  int checks;
  int failures;
  int wr_count;
  logic gnt_toggle;
  logic [45:0] exp_q[$];

  vga_console_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .char_valid_i (char_valid_i),
    .char_data_i  (char_data_i),
    .char_ready_o (char_ready_o),
    .buf_req_o    (buf_req_o),
    .buf_gnt_i    (buf_gnt_i),
    .buf_waddr_o  (buf_waddr_o),
    .buf_wdata_o  (buf_wdata_o),
    .buf_wstrb_o  (buf_wstrb_o),
    .cursor_col_o (cursor_col_o),
    .cursor_row_o (cursor_row_o),
    .busy_o       (busy_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    gnt_toggle = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (gnt_toggle) buf_gnt_i = ~buf_gnt_i;
    end
  end

  function automatic logic [45:0] char_word(input int tile, input logic [7:0] ch);
    logic [9:0] a;
    logic [3:0] s;
    a = 10'(tile / 4);
    s = 4'(1 << (tile % 4));
    return {a, s, {4{ch}}};
  endfunction

  function automatic logic [45:0] clr_word(input int addr);
    return {10'(addr), 4'hF, 32'h20202020};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic send_char(input logic [7:0] c);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    while (!char_ready_o && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!char_ready_o) check("ready_timeout", 64'(char_ready_o), 64'd1);
    char_valid_i = 1'b1;
    char_data_i  = c;
    @(posedge clk);
    #1;
    char_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) check("idle_timeout", 64'(busy_o), 64'd0);
  endtask

  task automatic push_row_clear(input int r);
    for (int i = 0; i < 20; i++) exp_q.push_back(clr_word(r * 20 + i));
  endtask

  // Scoreboard monitor: every granted write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst_i && buf_req_o && buf_gnt_i) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%0h/%0h/%0h expected=none",
                 buf_waddr_o, buf_wstrb_o, buf_wdata_o);
      end else begin
        logic [45:0] e;
        e = exp_q.pop_front();
        if ({buf_waddr_o, buf_wstrb_o, buf_wdata_o} !== e) begin
          failures++;
          $display("FAIL write_%0d actual=%0h/%0h/%0h expected=%0h/%0h/%0h", wr_count,
                   buf_waddr_o, buf_wstrb_o, buf_wdata_o, e[45:36], e[35:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    int base;
    int bad;
    int n;
    checks       = 0;
    failures     = 0;
    wr_count     = 0;
    rst_i        = 1'b1;
    buf_gnt_i    = 1'b0;
    char_valid_i = 1'b0;
    char_data_i  = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_req", 64'(buf_req_o), 64'd0);
    check("rst_ready", 64'(char_ready_o), 64'd1);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_cursor", {cursor_row_o, cursor_col_o}, 64'd0);
    check("rst_port", {buf_waddr_o, buf_wstrb_o, buf_wdata_o}, 64'd0);

    // 1: single printable with grant held high
    buf_gnt_i = 1'b1;
    exp_q.push_back(char_word(0, 8'h41));
    send_char(8'h41);
    @(negedge clk);
    check("t1_req_n1", 64'(buf_req_o), 64'd1);
    check("t1_ready_n1", 64'(char_ready_o), 64'd0);
    @(negedge clk);
    check("t1_ready_n2", 64'(char_ready_o), 64'd1);
    check("t1_cursor", {cursor_row_o, cursor_col_o}, {5'd0, 7'd1});

    // 2: grant withheld for 5 cycles
    buf_gnt_i = 1'b0;
    base = wr_count;
    exp_q.push_back(char_word(1, 8'h42));
    send_char(8'h42);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_port", {buf_req_o, buf_waddr_o, buf_wstrb_o, buf_wdata_o},
            {1'b1, 10'd0, 4'b0010, 32'h42424242});
      check("t2_hold_col", 64'(cursor_col_o), 64'd1);
      @(posedge clk);
      #1;
    end
    buf_gnt_i = 1'b1;
    @(negedge clk);
    check("t2_grant_port", {buf_req_o, buf_waddr_o, buf_wstrb_o, buf_wdata_o},
          {1'b1, 10'd0, 4'b0010, 32'h42424242});
    check("t2_grant_col", 64'(cursor_col_o), 64'd1);
    @(negedge clk);
    check("t2_after_col", 64'(cursor_col_o), 64'd2);
    check("t2_after_req", 64'(buf_req_o), 64'd0);
    check("t2_one_write", 64'(wr_count - base), 64'd1);

    // CR, then ignored code
    send_char(8'h0D);
    wait_idle(10);
    check("cr_cursor", {cursor_row_o, cursor_col_o}, 64'd0);
    base = wr_count;
    send_char(8'h01);
    repeat (3) @(negedge clk);
    check("ignored_no_write", 64'(wr_count - base), 64'd0);
    check("ignored_ready", 64'(char_ready_o), 64'd1);

    // 3: fill row 0 to column 79, then wrap with line clear
    for (int t = 0; t < 79; t++) begin
      exp_q.push_back(char_word(t, 8'h2E));
      send_char(8'h2E);
      wait_idle(20);
    end
    check("t3_at_79", {cursor_row_o, cursor_col_o}, {5'd0, 7'd79});
    exp_q.push_back(char_word(79, 8'h5A));
    push_row_clear(1);
    base = wr_count;
    send_char(8'h5A);
    wait_idle(100);
    check("t3_writes", 64'(wr_count - base), 64'd21);
    check("t3_cursor", {cursor_row_o, cursor_col_o}, {5'd1, 7'd0});

    // 4: LF down to row 29, then wrap to row 0
    for (int r = 2; r < 30; r++) begin
      push_row_clear(r);
      send_char(8'h0A);
      wait_idle(100);
    end
    check("t4_row29", 64'(cursor_row_o), 64'd29);
    push_row_clear(0);
    base = wr_count;
    send_char(8'h0A);
    wait_idle(100);
    check("t4_wrap_writes", 64'(wr_count - base), 64'd20);
    check("t4_wrap_cursor", {cursor_row_o, cursor_col_o}, 64'd0);
    check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // BS at column 0 does nothing
    base = wr_count;
    send_char(8'h08);
    repeat (3) @(negedge clk);
    check("bs0_no_write", 64'(wr_count - base), 64'd0);
    check("bs0_cursor", {cursor_row_o, cursor_col_o}, 64'd0);

    // BS at column 5 blanks tile 4
    for (int t = 0; t < 5; t++) begin
      exp_q.push_back(char_word(t, 8'h61 + 8'(t)));
      send_char(8'h61 + 8'(t));
      wait_idle(20);
    end
    exp_q.push_back(char_word(4, 8'h20));
    base = wr_count;
    send_char(8'h08);
    wait_idle(20);
    repeat (2) @(negedge clk);
    check("bs5_writes", 64'(wr_count - base), 64'd1);
    check("bs5_cursor", {cursor_row_o, cursor_col_o}, {5'd0, 7'd4});

    // 5: full clear with toggling grant
    for (int i = 0; i < 600; i++) exp_q.push_back(clr_word(i));
    base = wr_count;
    gnt_toggle = 1'b1;
    send_char(8'h0C);
    bad = 0;
    n = 0;
    while ((wr_count - base) < 600 && n < 5000) begin
      @(negedge clk);
      #2;
      if (!busy_o) bad++;
      n++;
    end
    gnt_toggle = 1'b0;
    buf_gnt_i = 1'b1;
    check("t5_writes", 64'(wr_count - base), 64'd600);
    check("t5_busy_held", 64'(bad), 64'd0);
    wait_idle(20);
    repeat (2) @(negedge clk);
    check("t5_idle", {busy_o, char_ready_o}, 64'b01);
    check("t5_cursor", {cursor_row_o, cursor_col_o}, 64'd0);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // 6: reset in the middle of a full clear
    exp_q.push_back(char_word(0, 8'h71));
    send_char(8'h71);
    wait_idle(20);
    check("t6_pre_cursor", {cursor_row_o, cursor_col_o}, {5'd0, 7'd1});
    for (int i = 0; i < 600; i++) exp_q.push_back(clr_word(i));
    base = wr_count;
    send_char(8'h0C);
    n = 0;
    while ((wr_count - base) < 300 && n < 2000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("t6_reached_300", 64'(wr_count - base), 64'd300);
    rst_i = 1'b1;
    #1;
    check("t6_req_drop", 64'(buf_req_o), 64'd0);
    check("t6_state", {busy_o, char_ready_o}, 64'b01);
    check("t6_cursor", {cursor_row_o, cursor_col_o}, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (buf_req_o) bad++;
    end
    check("t6_no_req_after", 64'(bad), 64'd0);
    check("t6_idle_after", 64'(busy_o), 64'd0);

    // Final report
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_console_ctrl.md
Name: vga_console_ctrl

Overview:
Terminal-style text controller that turns an 8-bit character stream (e.g. from a UART receiver) into word writes to the 80x30 character buffer.
- Maintains a cursor and interprets control codes.
- Runs line-clear and full-screen-clear sequences.
- Competes for the buffer write port through a req/gnt handshake with the port arbiter; the AXI path has priority there.
- Exports the cursor position for display overlay.

Parameters:
N_COL, 80, text columns
N_ROW, 30, text rows
BUF_ADDR_WIDTH, 10, buffer word-address width
DATA_WIDTH, 32, buffer word width (4 chars/word)
FILL_CHAR, 8'h20, character written by clears and backspace

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous, active-high reset
char_valid_i  in  1  input character valid
char_data_i  in  8  input character code
char_ready_o  out  1  controller accepts a character this cycle
buf_req_o  out  1  write request to buffer port arbiter
buf_gnt_i  in  1  arbiter grant; write happens in cycle where req && gnt
buf_waddr_o  out  BUF_ADDR_WIDTH  buffer word address
buf_wdata_o  out  DATA_WIDTH  write data
buf_wstrb_o  out  DATA_WIDTH/8  byte strobes
cursor_col_o  out  7  cursor column 0..N_COL-1
cursor_row_o  out  5  cursor row 0..N_ROW-1
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, cursor (0,0), clear counter 0.
  - buf_req_o=0, buf_waddr_o=0, buf_wdata_o=0, buf_wstrb_o=0, busy_o=0, char_ready_o=1.
  - Reset asserted mid-sequence aborts the sequence at once; no further requests are issued.
- States: IDLE, WRITE, CLR_LINE, CLR_ALL.
- char_ready_o=1 only in IDLE; a character is accepted when char_valid_i && char_ready_o.
- Decoding in the acceptance cycle:
  - Printable 0x20-0x7E:
    - tile = row*N_COL+col; waddr = tile>>2; wstrb = 1<<tile[1:0]; wdata = char replicated in all 4 byte lanes.
    - Go to WRITE.
    - After the grant: col+1. If col was N_COL-1, col=0 and row advance.
  - 0x0D CR: col=0; stay IDLE; no write.
  - 0x0A LF: row advance.
  - 0x08 BS:
    - If col>0: col-1 and write FILL_CHAR at the new position (WRITE); the cursor does not move after that write.
    - If col=0: no action.
  - 0x0C FF: cursor (0,0); go to CLR_ALL.
  - Any other code: accepted and ignored.
- Row advance:
  - row+1, wrapping N_ROW-1 -> 0; there is no scrolling.
  - Then CLR_LINE on the new row: word addresses row*20 .. row*20+19, wstrb=4'hF, wdata=FILL_CHAR x4.
- CLR_ALL: word addresses 0..599, same data and strobes; returns to IDLE after word 599 is granted.
- Handshake:
  - buf_req_o and the addr/data/strb outputs are registered and stay stable until the cycle with buf_gnt_i=1.
  - In a clear sequence, the next word is presented in the following cycle, so req stays high continuously.
  - buf_gnt_i while buf_req_o=0 is ignored.
- Latency:
  - Character accepted in cycle N -> buf_req_o=1 in N+1.
  - With gnt in N+1: cursor updated and char_ready_o=1 in N+2.
  - Row clear with continuous grant: 20 cycles.
  - Full clear with continuous grant: 600 cycles.
- Cursor outputs are registered and update in the cycle after the relevant grant or decode.
- Width rules:
  - tile is computed in 12 bits (max 2399); waddr is tile[11:2].
  - Clear counter is 10 bits; the last-word compare is against (N_ROW*N_COL/4)-1.

Decomposition:
- Shared package vga_pkg:
  - N_COL, N_ROW, WORDS_PER_ROW (=N_COL/4), TOTAL_WORDS (=600).
  - Control codes CR/LF/BS/FF.
  - State encoding (2-bit).
- One sub-module, vga_fill_seq:
  - Inputs: start pulse, base address, word count.
  - Produces the address sequence under the req/gnt handshake.
  - Signals done.
  - Used by both CLR_LINE and CLR_ALL.

Test Plan:
1. After reset, send 'A' (0x41) with gnt tied 1 -> one write: waddr=0, wstrb=4'b0001, wdata=32'h41414141; cursor (1,0); char_ready_o back high 2 cycles after acceptance.
2. Hold gnt=0 for 5 cycles, then 1 -> req, addr, data and strobe stable for all 6 cycles; exactly one write; cursor updated only after the grant.
3. Place cursor at (79,0) and send 'Z' -> write at waddr=19 with wstrb=4'b1000, then 20 writes at waddr 20..39 with wstrb=4'hF and data 32'h20202020; cursor (0,1).
4. Cursor at row 29, send LF -> row wraps to 0; words 0..19 cleared. Separately send BS at col 0 -> no write; BS at col 5 -> FILL_CHAR written at tile 4; cursor col 4.
5. Send FF with gnt toggling 1,0 -> exactly 600 distinct writes covering 0..599; cursor (0,0); busy_o high throughout; IDLE afterwards.
6. Assert rst_i at word 300 of an FF clear -> buf_req_o drops asynchronously; cursor (0,0); IDLE; no further requests issued.
